// File: rtl/token_time_gen.sv
// rtl/token_time_gen.sv - parking token issuer with LFSR token source and time-unit counter
// Issues a 3-bit token on a fresh request rise and expires it after HOLD_LIMIT time units.
module token_time_gen #(
  parameter int unsigned TICK_DIV   = 50,
  parameter int unsigned HOLD_LIMIT = 16,
  parameter logic [2:0]  LFSR_SEED  = 3'b101
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       request,
  output logic [2:0] system_token,
  output logic       token_valid,
  output logic       token_expired,
  output logic [7:0] TimeData,
  output logic       time_wrap
);

  // An all-zero seed would lock the LFSR, so it is substituted.
  localparam logic [2:0]  SEED      = (LFSR_SEED == 3'b000) ? 3'b001 : LFSR_SEED;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    EXPIRED
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] presc;
  logic        tick;
  logic [2:0]  lfsr;
  logic        request_d;
  logic        rise;
  logic [7:0]  hold_cnt;
  logic [7:0]  hold_cnt_next;
  logic [2:0]  token_next;
  logic        valid_next;
  logic        expired_next;

  assign tick = (presc == TICK_LAST);
  assign rise = request & ~request_d;

  // request_d resets high so a request held through reset is not seen as a rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      TimeData  <= '0;
      time_wrap <= 1'b0;
      lfsr      <= SEED;
      request_d <= 1'b1;
    end else begin
      presc     <= tick ? 16'd0 : presc + 16'd1;
      time_wrap <= tick && (TimeData == 8'hFF);
      if (tick) begin
        TimeData <= TimeData + 8'd1;
      end
      lfsr      <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
      request_d <= request;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      system_token  <= '0;
      token_valid   <= 1'b0;
      token_expired <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_cnt_next;
      system_token  <= token_next;
      token_valid   <= valid_next;
      token_expired <= expired_next;
    end
  end

  // A falling request has priority over a simultaneous hold timeout.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    token_next    = system_token;
    valid_next    = token_valid;
    expired_next  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next    = HOLD;
          token_next    = lfsr;
          valid_next    = 1'b1;
          hold_cnt_next = '0;
        end
      end
      HOLD: begin
        if (!request) begin
          state_next = IDLE;
          token_next = '0;
          valid_next = 1'b0;
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_next   = EXPIRED;
            token_next   = '0;
            valid_next   = 1'b0;
            expired_next = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt + 8'd1;
          end
        end
      end
      EXPIRED: begin
        if (!request) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        token_next = '0;
        valid_next = 1'b0;
      end
    endcase
  end

endmodule
